// File: rtl/score_arbiter.sv
// Two-player BCD score keeper: queues point pulses per player and serves them one at a time.
// Optional macro SCORE_DEUCE_EN requires a 2-point lead on top of reaching WIN_SCORE.
module score_arbiter #(
  parameter logic [7:0] WIN_SCORE = 8'h11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       point_p1,
  input  logic       point_p2,
  input  logic       new_game,
  output logic [3:0] p1_bcd0,
  output logic [3:0] p1_bcd1,
  output logic [3:0] p2_bcd0,
  output logic [3:0] p2_bcd1,
  output logic       game_over,
  output logic [1:0] winner,
  output logic       busy,
  output logic       overrun
);

  typedef enum logic [1:0] {IDLE = 2'd0, INC = 2'd1, CHECK = 2'd2, OVER = 2'd3} state_t;

  state_t      state_r;
  logic [1:0]  pend_r;
  logic        gnt_r;
  logic        tie_r;
  logic [7:0]  p1_r;
  logic [7:0]  p2_r;
  logic        game_over_r;
  logic [1:0]  winner_r;
  logic        overrun_r;

  logic [1:0]  pulse_s;
  logic        gnt_valid_s;
  logic        gnt_sel_s;
  logic [1:0]  gnt_clr_s;
  logic [1:0]  pend_keep_s;
  logic        win_s;
  logic        enter_over_s;
  logic [7:0]  gbin_s;
  logic [7:0]  wbin_s;
`ifdef SCORE_DEUCE_EN
  logic [7:0]  obin_s;
`endif

  // Saturating two-digit BCD increment (99 stays 99).
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99) r = v;
    else if (v[3:0] == 4'h9) r = {v[7:4] + 4'h1, 4'h0};
    else r = {v[7:4], v[3:0] + 4'h1};
    return r;
  endfunction

  function automatic logic [7:0] bcd_to_bin(input logic [7:0] v);
    return ({4'h0, v[7:4]} * 8'd10) + {4'h0, v[3:0]};
  endfunction

  // Grant selection, pending-flag bookkeeping and win evaluation.
  always_comb begin
    pulse_s     = {point_p2, point_p1};
    gnt_valid_s = (state_r == IDLE) && (pend_r != 2'b00);
    if (pend_r == 2'b11) gnt_sel_s = tie_r;
    else gnt_sel_s = pend_r[1];
    if (gnt_valid_s) gnt_clr_s = gnt_sel_s ? 2'b10 : 2'b01;
    else gnt_clr_s = 2'b00;
    pend_keep_s = pend_r & ~gnt_clr_s;
    gbin_s = bcd_to_bin(gnt_r ? p2_r : p1_r);
    wbin_s = bcd_to_bin(WIN_SCORE);
`ifdef SCORE_DEUCE_EN
    obin_s = bcd_to_bin(gnt_r ? p1_r : p2_r);
    win_s  = (gbin_s >= wbin_s) && (gbin_s >= obin_s + 8'd2);
`else
    win_s  = (gbin_s >= wbin_s);
`endif
    enter_over_s = (state_r == CHECK) && win_s;
  end

  // Main FSM with scores, flags and status registers.
  always_ff @(posedge clk) begin
    if (!reset || new_game) begin
      state_r     <= IDLE;
      pend_r      <= 2'b00;
      gnt_r       <= 1'b0;
      tie_r       <= 1'b0;
      p1_r        <= 8'h00;
      p2_r        <= 8'h00;
      game_over_r <= 1'b0;
      winner_r    <= 2'b00;
      overrun_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (gnt_valid_s) begin
            gnt_r   <= gnt_sel_s;
            state_r <= INC;
            if (pend_r == 2'b11) tie_r <= ~tie_r;
          end
        end
        INC: begin
          if (gnt_r) p2_r <= bcd_inc(p2_r);
          else p1_r <= bcd_inc(p1_r);
          state_r <= CHECK;
        end
        CHECK: begin
          if (win_s) begin
            state_r     <= OVER;
            game_over_r <= 1'b1;
            winner_r    <= gnt_r ? 2'b10 : 2'b01;
          end else begin
            state_r <= IDLE;
          end
        end
        OVER: state_r <= OVER;
        default: state_r <= IDLE;
      endcase
      // Once a winner is declared, further points are neither queued nor flagged as overruns.
      if (enter_over_s || (state_r == OVER)) begin
        pend_r <= 2'b00;
      end else begin
        pend_r <= pend_keep_s | pulse_s;
        if ((pend_keep_s & pulse_s) != 2'b00) overrun_r <= 1'b1;
      end
    end
  end

  assign p1_bcd0   = p1_r[3:0];
  assign p1_bcd1   = p1_r[7:4];
  assign p2_bcd0   = p2_r[3:0];
  assign p2_bcd1   = p2_r[7:4];
  assign game_over = game_over_r;
  assign winner    = winner_r;
  assign overrun   = overrun_r;
  assign busy      = (state_r != IDLE) || (pend_r != 2'b00);

endmodule

// File: tb/tb_score_arbiter.sv
// Testbench for score_arbiter: decimal-score reference model checked every cycle,
// directed scenarios with hand-computed expectations, then randomized play.
module tb_score_arbiter;

  localparam logic [7:0] WIN = 8'h11;
  localparam int WIN_DEC = 11;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic point_p1 = 1'b0;
  logic point_p2 = 1'b0;
  logic new_game = 1'b0;
  logic [3:0] p1_bcd0, p1_bcd1, p2_bcd0, p2_bcd1;
  logic game_over;
  logic [1:0] winner;
  logic busy, overrun;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: plain decimal scores and a service age counter.
  int m_sc[2];
  bit [1:0] m_pend;
  int m_age;
  int m_who;
  bit m_over;
  int m_winner;
  bit m_ovr;
  int m_tie;

  score_arbiter #(.WIN_SCORE(WIN)) dut (
    .clk(clk), .reset(reset), .point_p1(point_p1), .point_p2(point_p2),
    .new_game(new_game), .p1_bcd0(p1_bcd0), .p1_bcd1(p1_bcd1),
    .p2_bcd0(p2_bcd0), .p2_bcd1(p2_bcd1), .game_over(game_over),
    .winner(winner), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic bit m_wins(int s, int o);
`ifdef SCORE_DEUCE_EN
    return (s >= WIN_DEC) && (s - o >= 2);
`else
    return (s >= WIN_DEC);
`endif
  endfunction

  task automatic model_clear();
    m_sc[0] = 0; m_sc[1] = 0; m_pend = 2'b00; m_age = 0; m_who = 0;
    m_over = 1'b0; m_winner = 0; m_ovr = 1'b0; m_tie = 0;
  endtask

  task automatic model_edge(bit a, bit b, bit ng, bit rs);
    bit enter;
    enter = 1'b0;
    if (!rs || ng) begin
      model_clear();
      return;
    end
    if (m_over) return;
    if (m_age == 2) begin
      if (m_wins(m_sc[m_who], m_sc[1 - m_who])) begin
        enter = 1'b1; m_over = 1'b1; m_winner = m_who + 1;
      end
      m_age = 0;
    end else if (m_age == 1) begin
      if (m_sc[m_who] < 99) m_sc[m_who] = m_sc[m_who] + 1;
      m_age = 2;
    end else if (m_pend != 2'b00) begin
      if (m_pend == 2'b11) begin
        m_who = m_tie; m_tie = 1 - m_tie;
      end else begin
        m_who = m_pend[1] ? 1 : 0;
      end
      m_pend[m_who] = 1'b0;
      m_age = 1;
    end
    if (enter) begin
      m_pend = 2'b00;
    end else begin
      if (a) begin if (m_pend[0]) m_ovr = 1'b1; else m_pend[0] = 1'b1; end
      if (b) begin if (m_pend[1]) m_ovr = 1'b1; else m_pend[1] = 1'b1; end
    end
  endtask

  task automatic check_cycle();
    logic [20:0] got, exp;
    got = {p1_bcd1, p1_bcd0, p2_bcd1, p2_bcd0, game_over, winner, busy, overrun};
    exp = {4'(m_sc[0] / 10), 4'(m_sc[0] % 10), 4'(m_sc[1] / 10), 4'(m_sc[1] % 10),
           m_over, 2'(m_winner), (m_age != 0) || m_over || (m_pend != 2'b00), m_ovr};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL cycle_model t=%0t got=%h expected=%h", $time, got, exp);
    end
  endtask

  task automatic lit(string name, int actual, int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("FAIL %s got=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic step(bit a, bit b, bit ng, bit rs);
    point_p1 = a; point_p2 = b; new_game = ng; reset = rs;
    @(posedge clk);
    model_edge(a, b, ng, rs);
    @(negedge clk);
    check_cycle();
    point_p1 = 1'b0; point_p2 = 1'b0; new_game = 1'b0; reset = 1'b1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  function automatic int p1v();
    return p1_bcd1 * 10 + p1_bcd0;
  endfunction
  function automatic int p2v();
    return p2_bcd1 * 10 + p2_bcd0;
  endfunction

`ifdef SCORE_DEUCE_EN
  localparam int GO_AT_11 = 0;
  localparam int P1_AFTER_2ND = 12;
`else
  localparam int GO_AT_11 = 1;
  localparam int P1_AFTER_2ND = 11;
`endif

  initial begin
    model_clear();
    // Reset held for two cycles.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    lit("reset_digits", p1v() + p2v(), 0);
    lit("reset_busy", {30'd0, game_over, busy}, 0);
    lit("reset_winner", winner, 0);

    // Eleven player-1 points, four cycles apart.
    for (int i = 0; i < 11; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1);
      idle(2);
      if (i == 10) begin
        lit("win_digits_at_plus2", {p1_bcd1, p1_bcd0}, 8'h11);
        lit("win_go_at_plus2", game_over, 0);
      end
      idle(1);
    end
    lit("win_game_over", game_over, 1);
    lit("win_winner", winner, 1);

    step(1'b0, 1'b0, 1'b1, 1'b1);
    lit("new_game_clear", p1v() + p2v() + game_over + winner + overrun, 0);

    // Simultaneous pulses, twice: alternating tie winner.
    step(1'b1, 1'b1, 1'b0, 1'b1);
    idle(2);
    lit("tie1_p1_at_plus2", p1v() * 100 + p2v(), 100);
    idle(3);
    lit("tie1_p2_at_plus5", p2v(), 1);
    idle(1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    idle(2);
    lit("tie2_p2_first", p1v() * 100 + p2v(), 102);
    idle(3);
    lit("tie2_p1_second", p1v(), 2);
    lit("tie_overrun", overrun, 0);

    // BCD carry 09 -> 10.
    step(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1);
      idle(3);
    end
    lit("carry_digits", {p1_bcd1, p1_bcd0}, 8'h10);

    // Queued point while busy counts; pulse onto a set flag is dropped.
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    idle(1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    idle(6);
    lit("burst_p1", p1v(), 2);
    lit("burst_overrun", overrun, 1);

    // Reach 10-10, then player 1 scores twice; a later p2 point must be ignored.
    step(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1); idle(3);
      step(1'b0, 1'b1, 1'b0, 1'b1); idle(3);
    end
    step(1'b1, 1'b0, 1'b0, 1'b1); idle(3);
    lit("deuce_11_go", game_over, GO_AT_11);
    step(1'b1, 1'b0, 1'b0, 1'b1); idle(3);
    lit("deuce_12_go", game_over, 1);
    lit("deuce_12_winner", winner, 1);
    lit("deuce_12_p1", p1v(), P1_AFTER_2ND);
    step(1'b0, 1'b1, 1'b0, 1'b1); idle(3);
    lit("over_frozen_p2", p2v(), 10);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    lit("over_new_game", p1v() + p2v() + game_over + winner + busy, 0);

    // Randomized play with occasional new_game and reset.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(3) == 0), ($urandom_range(3) == 0),
           ($urandom_range(149) == 0), ($urandom_range(399) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
